// File: rtl/ins_memory.sv
// ins_memory: 1 KiB backing instruction memory (64 x 128-bit blocks) behind the I-cache.
// Latency: busywait is high for READ_LATENCY cycles from the accepting edge to data return.
// Backpressure: busywait holds the cache off; read/address/load are ignored while busy or done.
//
// Ports:
//   clk                      - system clock, all state changes on posedge
//   reset                    - synchronous active-low reset (array contents kept)
//   read, address[5:0]       - block refill request from the cache
//   readdata[127:0]          - returned block {word3, word2, word1, word0}
//   busywait                 - high while an access is in flight
//   load_en, load_addr[7:0], - program-load word write, accepted only in IDLE
//   load_data[31:0]            with no read pending
module ins_memory #(
  parameter int READ_LATENCY = 5,
  parameter int BLOCKS       = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         read,
  input  logic [5:0]   address,
  output logic [127:0] readdata,
  output logic         busywait,
  input  logic         load_en,
  input  logic [7:0]   load_addr,
  input  logic [31:0]  load_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [7:0]     counter, counter_nxt;
  logic [5:0]     addr_q, addr_nxt;
  logic           busy_nxt;
  logic [127:0]   rdata_nxt;
  logic [127:0]   rd_blk;
  logic           load_we;

  // Word array; deliberately not reset so a program survives a core reset.
  logic [31:0] mem [BLOCKS*4];

  // A load only lands in IDLE when no read is being accepted on the same edge.
  assign load_we = reset && (state == IDLE) && !read && load_en;

  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_addr] <= load_data;
    end
  end

  assign rd_blk = {mem[{addr_q, 2'd3}], mem[{addr_q, 2'd2}],
                   mem[{addr_q, 2'd1}], mem[{addr_q, 2'd0}]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      counter  <= 8'd0;
      addr_q   <= 6'd0;
      busywait <= 1'b0;
      readdata <= 128'd0;
    end else begin
      state    <= state_nxt;
      counter  <= counter_nxt;
      addr_q   <= addr_nxt;
      busywait <= busy_nxt;
      readdata <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    addr_nxt    = addr_q;
    busy_nxt    = busywait;
    rdata_nxt   = readdata;
    case (state)
      IDLE: begin
        if (read) begin
          addr_nxt    = address;
          busy_nxt    = 1'b1;
          // Counter reaches zero after READ_LATENCY-1 BUSY edges; the next
          // edge returns data, giving exactly READ_LATENCY busy cycles.
          counter_nxt = 8'(READ_LATENCY - 1);
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (counter == 8'd0) begin
          rdata_nxt = rd_blk;
          busy_nxt  = 1'b0;
          state_nxt = DONE;
        end else begin
          counter_nxt = counter - 8'd1;
        end
      end
      DONE: begin
        // One dead cycle so the cache can take the block and drop read.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ins_memory.sv
module tb_ins_memory;

  localparam int LAT = 5;

  logic         clk;
  logic         reset;
  logic         read;
  logic [5:0]   address;
  logic [127:0] readdata;
  logic         busywait;
  logic         load_en;
  logic [7:0]   load_addr;
  logic [31:0]  load_data;

  int checks = 0;
  int errors = 0;

  logic [31:0]  mdl [256];
  logic [127:0] sb [$];

  ins_memory #(.READ_LATENCY(LAT), .BLOCKS(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .read      (read),
    .address   (address),
    .readdata  (readdata),
    .busywait  (busywait),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_blk(input int b);
    return {mdl[4*b+3], mdl[4*b+2], mdl[4*b+1], mdl[4*b]};
  endfunction

  task automatic load_word(input int a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = 8'(a);
    load_data = d;
    mdl[a]    = d;
    tick();
    load_en   = 1'b0;
  endtask

  // Raise read and take the acceptance edge; expected block goes to the scoreboard.
  task automatic start_read(input int b);
    read    = 1'b1;
    address = 6'(b);
    sb.push_back(model_blk(b));
    tick();
    check("busy_rise", {127'd0, busywait}, 128'd1);
  endtask

  // Count remaining busy cycles until busywait falls, then compare data.
  task automatic wait_done(input int n0, input string tag);
    int n = n0;
    int guard = 0;
    logic [127:0] exp;
    while (busywait && guard < 50) begin
      tick();
      guard++;
      if (busywait) n++;
    end
    if (guard >= 50) begin
      errors++;
      $error("FAIL %s_timeout observed=busy expected=idle", tag);
    end
    check({tag, "_latency"}, 128'(n), 128'(LAT));
    exp = (sb.size() > 0) ? sb.pop_front() : 128'd0;
    check({tag, "_data"}, readdata, exp);
  endtask

  initial begin
    reset = 1'b0; read = 1'b0; address = 6'd0;
    load_en = 1'b0; load_addr = 8'd0; load_data = 32'd0;
    for (int i = 0; i < 256; i++) mdl[i] = 32'd0;

    tick(); tick();
    check("reset_busy", {127'd0, busywait}, 128'd0);
    check("reset_rdata", readdata, 128'd0);
    reset = 1'b1;
    tick();

    // Preload blocks 0, 3 and 7 (all words, so nothing read is uninitialised).
    load_word(12, 32'h11111111);
    load_word(13, 32'h22222222);
    load_word(14, 32'h33333333);
    load_word(15, 32'h44444444);
    for (int k = 0; k < 4; k++) load_word(k, 32'hB0000000 + 32'(k));
    for (int k = 0; k < 4; k++) load_word(28 + k, 32'h70000000 + 32'(k));

    // Basic refill of block 3.
    start_read(3);
    wait_done(1, "blk3");
    check("blk3_const", readdata, 128'h44444444_33333333_22222222_11111111);
    read = 1'b0;
    tick();

    // Address change mid-access must not redirect the read.
    start_read(3);
    tick();
    check("addrchg_busy", {127'd0, busywait}, 128'd1);
    address = 6'd7;
    wait_done(2, "addrchg");
    read = 1'b0;
    tick();

    // read held high: DONE then IDLE with busywait low, then a new access.
    start_read(3);
    wait_done(1, "hold1");
    tick();
    check("hold_done_busy", {127'd0, busywait}, 128'd0);
    sb.push_back(model_blk(3));
    tick();
    check("hold_restart_busy", {127'd0, busywait}, 128'd1);
    wait_done(1, "hold2");
    read = 1'b0;
    tick();

    // load during BUSY is dropped (model not updated).
    start_read(3);
    load_en = 1'b1; load_addr = 8'h0C; load_data = 32'hDEADBEEF;
    tick();
    load_en = 1'b0;
    check("busyload_busy", {127'd0, busywait}, 128'd1);
    wait_done(2, "busyload");
    read = 1'b0;
    tick();
    start_read(3);
    wait_done(1, "busyload_chk");
    check("busyload_word0", {96'd0, readdata[31:0]}, 128'h11111111);
    read = 1'b0;
    tick();

    // Reset on the 3rd BUSY cycle aborts the access.
    start_read(3);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_busy", {127'd0, busywait}, 128'd0);
    check("abort_rdata", readdata, 128'd0);
    void'(sb.pop_back());
    start_read(3);
    wait_done(1, "restart");
    read = 1'b0;
    tick();

    // read and load_en together in IDLE: read wins, load dropped.
    read = 1'b1; address = 6'd0;
    load_en = 1'b1; load_addr = 8'h00; load_data = 32'hAAAAAAAA;
    sb.push_back(model_blk(0));
    tick();
    load_en = 1'b0;
    check("rdld_busy", {127'd0, busywait}, 128'd1);
    wait_done(1, "rdld");
    read = 1'b0;
    tick();
    start_read(0);
    wait_done(1, "rdld_chk");
    check("rdld_word0", {96'd0, readdata[31:0]}, 128'hB0000000);
    read = 1'b0;
    tick();

    // Block 7 readback confirms address decoding of a second block.
    start_read(7);
    wait_done(1, "blk7");
    read = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_memory.md
Name: ins_memory

Overview:
- Backing instruction memory directly downstream of the instruction cache; services 128-bit block refills on a cache miss.
- Holds 64 blocks of 4 x 32-bit words (1 KiB), addressed by the 6-bit block address pc[9:4] that the cache drives.
- Multi-cycle read latency is set by a parameter and signalled with a busywait handshake.
- A word-wide program-load port fills the array before or between fetches.

Parameters:
- READ_LATENCY, 5, clock edges from read acceptance to data return; legal range 1..255.
- BLOCKS, 64, number of 128-bit blocks; fixed to 2^6 to match the 6-bit block address.

Ports:
- clk  input  1  single system clock; all state changes on posedge.
- reset  input  1  synchronous, active-low reset, sampled on posedge clk.
- read  input  1  block read request from the instruction cache.
- address  input  6  block address.
- readdata  output  128  returned block, {word3, word2, word1, word0}; word0 in bits [31:0].
- busywait  output  1  high while a read is in progress.
- load_en  input  1  program-load write strobe.
- load_addr  input  8  word address {block[5:0], offset[1:0]}.
- load_data  input  32  word to write.

Behaviour:
- Storage: 256 x 32-bit word array. Block b is words 4b..4b+3, and word 4b+k maps to readdata[32k+31:32k].
- Reset (reset==0 at posedge):
  - state=IDLE, busywait=0, readdata=0, counter=0.
  - Array contents are preserved and are not cleared.
  - Reset overrides every other input on that edge.
- IDLE:
  - read==1 at posedge: latch address into addr_q, set busywait=1 (registered, same edge), load counter=READ_LATENCY-1, go to BUSY.
  - Otherwise, load_en==1 at posedge: mem[load_addr]=load_data.
  - read and load_en both high in IDLE: read wins and the load is dropped.
- BUSY:
  - Counter decrements each posedge.
  - On the edge where counter==0: readdata={mem[4*addr_q+3], mem[4*addr_q+2], mem[4*addr_q+1], mem[4*addr_q]}, busywait=0, go to DONE.
  - busywait is therefore high for exactly READ_LATENCY cycles.
  - read and address are ignored while BUSY. A mid-access address change has no effect; addr_q is used.
  - read dropping mid-access does not abort the access.
  - load_en is ignored in BUSY and DONE, with no write.
- DONE:
  - Lasts one cycle; read is ignored.
  - This gives the cache one edge to write the block and drop its request.
  - Next state is always IDLE.
  - If read is still high in the following IDLE cycle, a new access starts.
- readdata is held stable from completion until the next completion or reset. It is never X after reset.
- Reads of never-loaded words return the array's initial value. The bench must preload the array before reading.
- Reset mid-BUSY aborts the access: busywait=0 on that edge, readdata=0, no data returned.

Test Plan:
- Reset, then load block 3 words 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; read=1, address=3 -> busywait rises at acceptance edge, stays high 5 cycles, falls with readdata=0x44444444_33333333_22222222_11111111.
- Start read of block 3; change address to 7 on the 2nd BUSY cycle -> returned block is still block 3 and latency is still 5.
- Hold read=1 continuously after completion -> exactly one DONE cycle with busywait=0, then a second access starts; busywait high again 5 cycles later returns the same block.
- load_en=1, load_addr=8'h0C, load_data=0xDEADBEEF during BUSY -> no write occurs; a subsequent read of block 3 shows word0 unchanged at 0x11111111.
- Drive reset=0 on the 3rd BUSY cycle -> busywait=0 and readdata=0 on that edge, state IDLE. After reset=1 with read=1, the access restarts with full 5-cycle latency and block contents intact.
- read and load_en both high in IDLE (load_addr=8'h00, data 0xAAAAAAAA) -> read accepted, load dropped; block 0 word0 is unchanged.
